// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam int unsigned PC_INC        = 4;
  localparam int unsigned PC_ALIGN_MASK = 3;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating 32-bit event counter used for fetch performance statistics.
module fetch_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 32'd0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency imem, handles stall/redirect/halt.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_squashed counter ports.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned          DBITS          = 32,
  parameter int unsigned          IMEM_ADDR_BITS = 11,
  parameter logic [DBITS-1:0]     START_PC       = DBITS'(32'h0000_0040),
  parameter logic [DBITS-1:0]     HALT_INST      = DBITS'(32'hFFFF_FFFF)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      redirect_en,
  input  logic [DBITS-1:0]          redirect_pc,
  output logic [IMEM_ADDR_BITS-1:0] imem_addr,
  input  logic [DBITS-1:0]          imem_rdata,
  output logic [DBITS-1:0]          ir,
  output logic [DBITS-1:0]          ir_pc,
  output logic                      ir_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_squashed,
`endif
  output logic                      halted
);

  state_t           state;
  logic [DBITS-1:0] fetch_pc;
  logic [DBITS-1:0] resp_pc;
  logic             resp_valid;
  logic [DBITS-1:0] hold_data;
  logic             hold_valid;
  logic [DBITS-1:0] rdata_c;
  logic [DBITS-1:0] redirect_tgt_c;

  assign imem_addr      = fetch_pc[IMEM_ADDR_BITS+1:2];
  assign redirect_tgt_c = redirect_pc & ~DBITS'(PC_ALIGN_MASK);
  // While stalled the memory re-reads fetch_pc, so the response word is parked in hold_data.
  assign rdata_c        = hold_valid ? hold_data : imem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_BOOT;
      fetch_pc   <= START_PC;
      resp_pc    <= '0;
      resp_valid <= 1'b0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      ir         <= '0;
      ir_pc      <= '0;
      ir_valid   <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_RUN;
          if (redirect_en) begin
            fetch_pc   <= redirect_tgt_c;
            resp_valid <= 1'b0;
            ir_valid   <= 1'b0;
            hold_valid <= 1'b0;
          end else begin
            resp_pc    <= START_PC;
            resp_valid <= 1'b1;
            fetch_pc   <= START_PC + DBITS'(PC_INC);
          end
        end
        S_RUN: begin
          if (redirect_en) begin
            fetch_pc   <= redirect_tgt_c;
            resp_valid <= 1'b0;
            ir_valid   <= 1'b0;
            hold_valid <= 1'b0;
          end else if (stall) begin
            if (!hold_valid) begin
              hold_data  <= imem_rdata;
              hold_valid <= 1'b1;
            end
          end else begin
            ir         <= rdata_c;
            ir_pc      <= resp_pc;
            ir_valid   <= resp_valid;
            resp_pc    <= fetch_pc;
            resp_valid <= 1'b1;
            fetch_pc   <= fetch_pc + DBITS'(PC_INC);
            hold_valid <= 1'b0;
            if (resp_valid && (rdata_c == HALT_INST)) begin
              resp_valid <= 1'b0;
              halted     <= 1'b1;
              state      <= S_HALT;
            end
          end
        end
        S_HALT: begin
          if (redirect_en) begin
            halted     <= 1'b0;
            fetch_pc   <= redirect_tgt_c;
            resp_valid <= 1'b0;
            ir_valid   <= 1'b0;
            hold_valid <= 1'b0;
            state      <= S_RUN;
          end else if (!stall) begin
            ir_valid <= 1'b0;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetched_inc_c;
  logic squashed_inc_c;

  assign fetched_inc_c  = (state == S_RUN) && !redirect_en && !stall && resp_valid;
  assign squashed_inc_c = redirect_en && (ir_valid || resp_valid);

  fetch_perf_counter u_cnt_fetched (
    .clk   (clk),
    .reset (reset),
    .inc   (fetched_inc_c),
    .count (perf_fetched)
  );

  fetch_perf_counter u_cnt_squashed (
    .clk   (clk),
    .reset (reset),
    .inc   (squashed_inc_c),
    .count (perf_squashed)
  );
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random stall/redirect traffic.
module tb_inst_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  logic [31:0] mem [0:2047];

  int total;
  int bad;

  // reference model: stream-level view of what the fetch stage must deliver
  logic        m_boot;
  logic        m_halted;
  int          m_fill;
  logic [31:0] m_exp_pc;
  int          m_fetched;
  int          m_squashed;

  inst_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed),
`endif
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot     = 1'b1;
    m_halted   = 1'b0;
    m_fill     = 0;
    m_exp_pc   = 32'h0000_0040;
    m_fetched  = 0;
    m_squashed = 0;
  endtask

  // One clock: drive inputs, advance, then check against the model.
  task automatic cyc(input logic s, input logic r, input logic [31:0] rp);
    logic [31:0] p_ir, p_pc, p_addr, w;
    logic        p_v;
    stall       = s;
    redirect_en = r;
    redirect_pc = rp;
    p_ir   = ir;
    p_pc   = ir_pc;
    p_v    = ir_valid;
    p_addr = 32'(imem_addr);
    @(posedge clk);
    #1;
    if (r) begin
      if (p_v || (!m_halted && m_fill >= 1)) m_squashed++;
      m_exp_pc = rp & ~32'h3;
      m_fill   = 0;
      m_halted = 1'b0;
      m_boot   = 1'b0;
      chk("redir_valid", 32'(ir_valid), 32'd0);
      chk("redir_addr", 32'(imem_addr), 32'(m_exp_pc[12:2]));
    end else if (m_halted) begin
      chk("halt_pc", ir_pc, p_pc);
      chk("halt_valid", 32'(ir_valid), s ? 32'(p_v) : 32'd0);
    end else if (s && !m_boot) begin
      chk("stall_ir", ir, p_ir);
      chk("stall_pc", ir_pc, p_pc);
      chk("stall_valid", 32'(ir_valid), 32'(p_v));
      chk("stall_addr", 32'(imem_addr), p_addr);
    end else begin
      m_boot = 1'b0;
      if (m_fill < 2) m_fill++;
      if (m_fill >= 2) begin
        w = mem[m_exp_pc[12:2]];
        chk("adv_valid", 32'(ir_valid), 32'd1);
        chk("adv_pc", ir_pc, m_exp_pc);
        chk("adv_ir", ir, w);
        m_fetched++;
        if (w == HALT) m_halted = 1'b1;
        m_exp_pc = m_exp_pc + 32'd4;
        chk("adv_addr", 32'(imem_addr), 32'((m_exp_pc + 32'd4) >> 2) & 32'h7FF);
      end else begin
        chk("fill_valid", 32'(ir_valid), 32'd0);
      end
    end
    chk("halted", 32'(halted), 32'(m_halted));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_squashed", perf_squashed, 32'(m_squashed));
`endif
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ir"}, ir, 32'd0);
    chk({tag, "_pc"}, ir_pc, 32'd0);
    chk({tag, "_valid"}, 32'(ir_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'h10);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_pf"}, perf_fetched, 32'd0);
    chk({tag, "_ps"}, perf_squashed, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] tgt;
    total       = 0;
    bad         = 0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i);
    model_reset();

    // reset state and pipeline fill from START_PC
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst");
    reset = 1'b0;
    cyc(0, 0, 0);
    chk("t1_addr", 32'(imem_addr), 32'h11);
    chk("t1_novalid", 32'(ir_valid), 32'd0);
    cyc(0, 0, 0);
    chk("t1_pc", ir_pc, 32'h40);
    chk("t1_ir", ir, 32'h10);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t2_pc48", ir_pc, 32'h48);

    // stall freezes everything; resumes without gap or duplicate
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("t2_pc4c", ir_pc, 32'h4C);
    chk("t2_ir4c", ir, 32'h13);

    // redirect with unaligned target
    cyc(0, 1, 32'h103);
    chk("t3_kill", 32'(ir_valid), 32'd0);
    cyc(0, 0, 0);
    chk("t3_bubble", 32'(ir_valid), 32'd0);
    cyc(0, 0, 0);
    chk("t3_pc", ir_pc, 32'h100);
    chk("t3_valid", 32'(ir_valid), 32'd1);

    // redirect beats stall
    cyc(0, 0, 0);
    cyc(1, 1, 32'h200);
    chk("t4_drop", 32'(ir_valid), 32'd0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t4_pc", ir_pc, 32'h200);

    // HALT at 0x50
    mem[20] = HALT;
    cyc(0, 1, 32'h40);
    for (int i = 0; i < 10 && !halted; i++) cyc(0, 0, 0);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_pc", ir_pc, 32'h50);
    chk("t5_ir", ir, HALT);
    chk("t5_valid", 32'(ir_valid), 32'd1);
    cyc(1, 0, 0);
    chk("t5_held", 32'(ir_valid), 32'd1);
    repeat (5) cyc(0, 0, 0);
    chk("t5_stopped", 32'(ir_valid), 32'd0);
    mem[20] = 32'd20;
    cyc(0, 1, 32'h40);
    chk("t5_unhalt", 32'(halted), 32'd0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t5_resume", ir_pc, 32'h40);

    // async reset between edges
    repeat (3) cyc(0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_values("arst");
    #1;
    reset = 1'b0;
    model_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t6_restart", ir_pc, 32'h40);

    // PC wraps at the top of the address space
    cyc(0, 1, 32'hFFFF_FFFE);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t6_top", ir_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("t6_wrap", ir_pc, 32'h0);
    chk("t6_wrap_ir", ir, 32'h0);

    // random stall/redirect traffic
    for (int n = 0; n < 400; n++) begin
      tgt = $urandom;
      cyc(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0, tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
